eq_serial_ctrl: RTL and testbench
=================================

EQ_SERIAL_CTRL -- requirements
Module: eq_serial_ctrl

Interface
REQ-001 SHALL have parameter: W, 8, operand width in bits; even, 2..32.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to compare a and b; sampled on the rising edge of clk.
REQ-005 SHALL have port: a  input  W  first operand; sampled only when start is accepted.
REQ-006 SHALL have port: b  input  W  second operand; sampled only when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while a comparison is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking a valid result.
REQ-009 SHALL have port: eq  output  1  1 = operands equal; valid from done and held until the next accepted start.
REQ-010 SHALL have port: mis_idx  output  clog2(W/2), min 1  index of the first mismatching 2-bit slice (slice 0 = bits [1:0]); 0 when eq=1.

Function
REQ-011 SHALL compare serially, one 2-bit slice per cycle, using a single combinational 2-bit equality slice (both bits equal) shared across all slices.
REQ-012 SHALL implement FSM states IDLE, CMP and DONE, plus a slice counter of width clog2(W/2).
REQ-013 IDLE: start=1 SHALL capture a and b into shift registers, clear the counter, and go to CMP; start=0 stays in IDLE.
REQ-014 CMP: each cycle SHALL evaluate slice bits [1:0] of the shift registers, then shift both registers right by 2 and increment the counter.
REQ-015 CMP, slice mismatch: SHALL go to DONE with eq<=0 and mis_idx<=current counter value (early termination).
REQ-016 CMP, slice match at counter = W/2-1: SHALL go to DONE with eq<=1 and mis_idx<=0.
REQ-017 CMP, slice match at counter < W/2-1: SHALL stay in CMP.
REQ-018 DONE: SHALL last exactly one cycle with done=1, then go to IDLE; if start=1 in DONE, the new request SHALL be accepted exactly as in IDLE (go to CMP).
REQ-019 busy SHALL be 1 exactly in CMP; done SHALL be 1 exactly in DONE; both are state-decoded and glitch-free.
REQ-020 start while in CMP SHALL be ignored; changes on a or b after acceptance SHALL NOT affect the result.
REQ-021 Latency SHALL be: start accepted at edge 0 -> slice j compared in cycle j+1 -> done high in cycle k+2, where k is the mismatching slice, or k = W/2-1 when the operands are equal.
REQ-022 eq and mis_idx SHALL hold their values through IDLE until updated by the next DONE entry.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, with busy=0, done=0, eq=0 and mis_idx=0, and clear the counter and shift registers, independent of clk.
REQ-024 reset asserted mid-CMP SHALL abort the comparison with no done pulse; the first start after reset deasserts SHALL operate normally.
REQ-025 No output SHALL be X after reset.

Verification (W=8)
REQ-026 a=8'hA5, b=8'hA5, start pulse at edge 0 -> busy=1 in cycles 1-4; done=1 in cycle 5 with eq=1 and mis_idx=0; then IDLE with eq held at 1.
REQ-027 a=8'hA5, b=8'hA4 -> mismatch in slice 0; done=1 in cycle 2 with eq=0 and mis_idx=0; busy=1 for cycle 1 only.
REQ-028 a=8'h25, b=8'hA5 -> mismatch in slice 3; done=1 in cycle 5 with eq=0 and mis_idx=3.
REQ-029 Start with a=b=8'h3C; then in cycle 2 assert start with a=8'h00, b=8'hFF and change a -> both ignored; done in cycle 5 with eq=1.
REQ-030 reset pulsed in cycle 2 of a comparison -> busy, done, eq and mis_idx all 0 without waiting for a clk edge, no done pulse; next start with a=8'h0F, b=8'h1F -> done 4 cycles after acceptance with eq=0 and mis_idx=2.
REQ-031 Back-to-back: start held high through the DONE cycle of a compare -> second compare is accepted with zero idle cycles between them; done pulses twice and each result is correct.

Source files
------------

// File: rtl/eq_serial_ctrl.sv
// Serial equality comparator: walks two W-bit operands two bits per cycle through
// one shared 2-bit equality slice, stopping at the first mismatching slice.
module eq_serial_ctrl #(
  parameter int W = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [W-1:0]                                a,
  input  logic [W-1:0]                                b,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        eq,
  output logic [((W/2 > 1) ? $clog2(W/2) : 1)-1:0]    mis_idx
);

  localparam int             CW   = (W/2 > 1) ? $clog2(W/2) : 1;
  localparam logic [CW-1:0]  LAST = CW'(W/2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_sa;
  logic [W-1:0]    r_sb;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_eq;
  logic [CW-1:0]   r_mis_idx;
  logic            w_slice_eq;

  // The one shared comparator always looks at the low slice of the shift registers.
  assign w_slice_eq = (r_sa[1:0] == r_sb[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sa      <= '0;
      r_sb      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_eq      <= 1'b0;
      r_mis_idx <= '0;
    end else begin
      case (r_state)
        // DONE accepts a new request exactly like IDLE, allowing back-to-back compares.
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CMP;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        CMP: begin
          r_sa  <= r_sa >> 2;
          r_sb  <= r_sb >> 2;
          r_cnt <= r_cnt + 1'b1;
          if (!w_slice_eq) begin
            r_eq      <= 1'b0;
            r_mis_idx <= r_cnt;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else if (r_cnt == LAST) begin
            r_eq      <= 1'b1;
            r_mis_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_state <= CMP;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign eq      = r_eq;
  assign mis_idx = r_mis_idx;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Scoreboard bench for eq_serial_ctrl (W=8): the driver pushes expected results from a
// slice-search reference model; a monitor checks every cycle after the clock edge.
module tb_eq_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         eq;
  logic [1:0]   mis_idx;

  eq_serial_ctrl #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .eq      (eq),
    .mis_idx (mis_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit eqv;
    int idx;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_off = 1'b1;
  int   bsy_lo = 1;
  int   bsy_hi = 0;
  bit   last_eq = 1'b0;
  int   last_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: find the lowest 2-bit slice where the operands differ.
  function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    output bit e, output int idx, output int k);
    e = 1'b1; idx = 0; k = W/2 - 1;
    for (int j = 0; j < W/2; j++) begin
      if (e && (ra[2*j +: 2] != rb[2*j +: 2])) begin
        e = 1'b0; idx = j; k = j;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge of the expected done cycle.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    bit   e;
    int   idx;
    int   k;
    int   acc;
    exp_t x;
    ref_model(ta, tb_v, e, idx, k);
    start = 1'b1; a = ta; b = tb_v;
    acc = cyc + 1;
    x.eqv = e; x.idx = idx; x.cyc = acc + k + 1;
    q.push_back(x);
    bsy_lo = acc; bsy_hi = acc + k;
    for (int c = 0; c < k + 2; c++) begin
      @(negedge clk);
      if (c < k + 1) begin
        start = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!mon_off) begin
        bit exp_done;
        exp_done = (q.size() > 0) && (q[0].cyc == cyc);
        chk("done", {31'b0, done}, {31'b0, exp_done});
        if (exp_done) begin
          last_eq  = q[0].eqv;
          last_idx = q[0].idx;
          void'(q.pop_front());
        end
        chk("busy", {31'b0, busy}, {31'b0, (cyc >= bsy_lo) && (cyc <= bsy_hi)});
        chk("eq", {31'b0, eq}, {31'b0, last_eq});
        chk("mis_idx", {30'b0, mis_idx}, 32'(last_idx));
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_eq", {31'b0, eq}, 32'd0);
    chk("rst_mis_idx", {30'b0, mis_idx}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_off = 1'b0;
    idle(2);

    issue(8'hA5, 8'hA5);
    idle(3);
    issue(8'hA5, 8'hA4);
    idle(2);
    issue(8'h25, 8'hA5);
    idle(2);
    issue(8'h3C, 8'h3C);
    idle(1);

    // Abort a compare with an asynchronous reset in its second busy cycle.
    mon_off = 1'b1;
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0; a = 8'h00;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", {31'b0, busy}, 32'd0);
    chk("async_done", {31'b0, done}, 32'd0);
    chk("async_eq", {31'b0, eq}, 32'd0);
    chk("async_mis_idx", {30'b0, mis_idx}, 32'd0);
    @(negedge clk);
    chk("abort_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    q.delete();
    last_eq = 1'b0; last_idx = 0;
    bsy_lo = 1; bsy_hi = 0;
    mon_off = 1'b0;
    issue(8'h0F, 8'h1F);

    // Back-to-back: start stays high through the DONE cycle.
    issue(8'h5A, 8'h5A);
    issue(8'h00, 8'h40);
    issue(8'hC3, 8'hC3);
    idle(2);

    for (int n = 0; n < 150; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (W'(2'($urandom_range(1, 3))) << (2 * $urandom_range(0, W/2 - 1)));
        default: rb = W'($urandom);
      endcase
      issue(ra, rb);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end

    idle(4);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
